// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: data word and memory-stage FSM states.
// SC_OK is the value a successful store-conditional writes back.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HELD = 2'd2
  } mem_state_t;

  localparam word_t SC_OK = 32'd1;

endpackage

// File: rtl/link_reg.sv
// LL/SC reservation register: set by a completed LL, cleared by a matching snoop or own store.
// Registered state, combinational compare; an LL completing in the same cycle as a clear wins.
module link_reg
  import cpu_types_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_set,
  input  logic [31:0] i_addr,
  input  logic        i_wr_hit,
  input  logic        i_snoop_inv,
  input  logic [31:0] i_snoop_addr,
  output logic        o_match,
  output logic        o_link_valid,
  output logic [31:0] o_link_addr
);

  logic  r_valid;
  word_t r_addr;
  logic  w_clr;

  // Addresses arrive word-aligned, so a full compare is a word compare.
  assign w_clr = (i_snoop_inv && (i_snoop_addr == r_addr)) ||
                 (i_wr_hit && (i_addr == r_addr));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
    end else if (i_set) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
    end else if (w_clr) begin
      r_valid <= 1'b0;
    end
  end

  assign o_match      = r_valid && (i_addr == r_addr);
  assign o_link_valid = r_valid;
  assign o_link_addr  = r_addr;

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues dcache requests, stalls until dhit, holds the result until advance.
// Requests are driven combinationally from EX/MEM; dhit never feeds dREN/dWEN.
module mem_stage
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        memread_in,
  input  logic        memwrite_in,
  input  logic        ll_in,
  input  logic        sc_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic        advance,
  input  logic        dhit,
  input  logic [31:0] dload,
  input  logic        snoop_inv,
  input  logic [31:0] snoop_addr,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  output logic [31:0] dmemload_out,
  output logic        mem_stall,
  output logic        link_valid,
  output logic [31:0] link_addr
);

  mem_state_t r_state, w_state_nxt;
  word_t      r_held;
  word_t      w_daddr, w_snoop_word, w_result, w_dmemload;
  logic       w_link_match, w_sc_fail, w_req, w_not_held;
  logic       w_ren, w_wen, w_done, w_unused;

  assign w_daddr      = {addr_in[31:2], 2'b00};
  assign w_snoop_word = {snoop_addr[31:2], 2'b00};
  assign w_unused     = ^{addr_in[1:0], snoop_addr[1:0]};

  assign w_not_held = (r_state != HELD);
  assign w_sc_fail  = sc_in && memwrite_in && !w_link_match;
  assign w_req      = (memread_in || memwrite_in) && !w_sc_fail;

  // A write wins over a simultaneous (illegal) read.
  assign w_ren  = memread_in && !memwrite_in && w_not_held && !RST;
  assign w_wen  = memwrite_in && w_not_held && !w_sc_fail && !RST;
  assign w_done = (w_ren || w_wen) && dhit;

  assign w_result = w_ren ? dload : (sc_in ? SC_OK : '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_req && !dhit)           w_state_nxt = BUSY;
        else if (w_req && !advance)   w_state_nxt = HELD;
      end
      // A withdrawn request (e.g. SC whose reservation was snooped away) must not land in HELD.
      BUSY: begin
        if (dhit && w_req)            w_state_nxt = advance ? IDLE : HELD;
      end
      HELD: begin
        if (advance)                  w_state_nxt = IDLE;
      end
      default:                        w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_held  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_done) r_held <= w_result;
    end
  end

  always_comb begin
    w_dmemload = '0;
    if (RST)                  w_dmemload = '0;
    else if (r_state == HELD) w_dmemload = r_held;
    else if (w_done)          w_dmemload = w_result;
  end

  link_reg u_link_reg (
    .i_clk        (CLK),
    .i_rst        (RST),
    .i_set        (w_done && w_ren && ll_in),
    .i_addr       (w_daddr),
    .i_wr_hit     (w_done && w_wen),
    .i_snoop_inv  (snoop_inv),
    .i_snoop_addr (w_snoop_word),
    .o_match      (w_link_match),
    .o_link_valid (link_valid),
    .o_link_addr  (link_addr)
  );

  assign dREN         = w_ren;
  assign dWEN         = w_wen;
  assign daddr        = w_daddr;
  assign dstore       = wdata_in;
  assign dmemload_out = w_dmemload;
  assign mem_stall    = (w_ren || w_wen) && !dhit;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: single-cycle vector table, multi-cycle corner sequences,
// and a randomized run against a reference model of the access/hold/reservation rules.
module tb_mem_stage;

  logic        CLK;
  logic        RST;
  logic        memread_in, memwrite_in, ll_in, sc_in;
  logic [31:0] addr_in, wdata_in;
  logic        advance, dhit;
  logic [31:0] dload;
  logic        snoop_inv;
  logic [31:0] snoop_addr;
  logic        dREN, dWEN, mem_stall, link_valid;
  logic [31:0] daddr, dstore, dmemload_out, link_addr;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .CLK          (CLK),
    .RST          (RST),
    .memread_in   (memread_in),
    .memwrite_in  (memwrite_in),
    .ll_in        (ll_in),
    .sc_in        (sc_in),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .advance      (advance),
    .dhit         (dhit),
    .dload        (dload),
    .snoop_inv    (snoop_inv),
    .snoop_addr   (snoop_addr),
    .dREN         (dREN),
    .dWEN         (dWEN),
    .daddr        (daddr),
    .dstore       (dstore),
    .dmemload_out (dmemload_out),
    .mem_stall    (mem_stall),
    .link_valid   (link_valid),
    .link_addr    (link_addr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    memread_in = 0; memwrite_in = 0; ll_in = 0; sc_in = 0;
    addr_in = '0; wdata_in = '0; advance = 1; dhit = 0; dload = '0;
    snoop_inv = 0; snoop_addr = '0;
  endtask

  task automatic set_req(input logic rd, input logic wr, input logic ll, input logic sc,
                         input logic [31:0] a, input logic [31:0] wd);
    memread_in = rd; memwrite_in = wr; ll_in = ll; sc_in = sc;
    addr_in = a; wdata_in = wd;
  endtask

  task automatic do_reset();
    RST = 1;
    idle_in();
    tick();
    RST = 0;
  endtask

  // Sample combinational outputs mid-cycle, well away from the clock edge.
  task automatic look(input string tag, input logic ren, input logic wen,
                      input logic stall, input logic [31:0] out);
    #2;
    chk1({tag, ".dREN"}, dREN, ren);
    chk1({tag, ".dWEN"}, dWEN, wen);
    chk1({tag, ".mem_stall"}, mem_stall, stall);
    chk32({tag, ".dmemload_out"}, dmemload_out, out);
  endtask

  task automatic look_link(input string tag, input logic v, input logic [31:0] a);
    chk1({tag, ".link_valid"}, link_valid, v);
    chk32({tag, ".link_addr"}, link_addr, a);
  endtask

  typedef struct {
    string       name;
    logic        rd, wr, ll, sc;
    logic [31:0] addr, wdata;
    logic        hit;
    logic [31:0] ld;
    logic        e_ren, e_wen, e_stall;
    logic [31:0] e_out, e_daddr;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input string nm, input logic rd, input logic wr, input logic ll,
                         input logic sc, input logic [31:0] a, input logic [31:0] wd,
                         input logic hit, input logic [31:0] ld, input logic er,
                         input logic ew, input logic es, input logic [31:0] eo,
                         input logic [31:0] ea);
    vec_t v;
    v.name = nm; v.rd = rd; v.wr = wr; v.ll = ll; v.sc = sc; v.addr = a; v.wdata = wd;
    v.hit = hit; v.ld = ld; v.e_ren = er; v.e_wen = ew; v.e_stall = es;
    v.e_out = eo; v.e_daddr = ea;
    vq.push_back(v);
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] base;
    case ($urandom_range(0, 3))
      0:       base = 32'h100;
      1:       base = 32'h104;
      2:       base = 32'h200;
      default: base = 32'h300;
    endcase
    return base | 32'($urandom_range(0, 3));
  endfunction

  // Reference model state
  logic        m_held, m_lv, m_pend;
  logic [31:0] m_hv, m_la;

  initial begin
    logic        e_ren, e_wen, e_stall, scf, done, rd, wr;
    logic [31:0] e_out, e_daddr;
    int          kind;

    RST = 1;
    idle_in();

    // Reset with a load presented: everything quiet, reservation empty.
    set_req(1, 0, 0, 0, 32'h100, 32'h0);
    tick();
    look("reset", 0, 0, 0, 32'h0);
    look_link("reset", 0, 32'h0);
    RST = 0;

    add_vec("nop",      0, 0, 0, 0, 32'h100, 32'h0,        1, 32'h1111, 0, 0, 0, 32'h0,        32'h100);
    add_vec("lw_miss",  1, 0, 0, 0, 32'h103, 32'h0,        0, 32'h2222, 1, 0, 1, 32'h0,        32'h100);
    add_vec("lw_hit",   1, 0, 0, 0, 32'h100, 32'h0,        1, 32'hCAFEF00D, 1, 0, 0, 32'hCAFEF00D, 32'h100);
    add_vec("sw_miss",  0, 1, 0, 0, 32'h204, 32'h12345678, 0, 32'h0,    0, 1, 1, 32'h0,        32'h204);
    add_vec("sw_hit",   0, 1, 0, 0, 32'h206, 32'h9ABCDEF0, 1, 32'h5555, 0, 1, 0, 32'h0,        32'h204);
    add_vec("rd_wr",    1, 1, 0, 0, 32'h300, 32'hAAAA5555, 0, 32'h0,    0, 1, 1, 32'h0,        32'h300);
    add_vec("sc_nolnk", 0, 1, 0, 1, 32'h200, 32'h7,        1, 32'h0,    0, 0, 0, 32'h0,        32'h200);
    add_vec("ll_hit",   1, 0, 1, 0, 32'h201, 32'h0,        1, 32'h0BADF00D, 1, 0, 0, 32'h0BADF00D, 32'h200);

    foreach (vq[i]) begin
      do_reset();
      set_req(vq[i].rd, vq[i].wr, vq[i].ll, vq[i].sc, vq[i].addr, vq[i].wdata);
      dhit = vq[i].hit; dload = vq[i].ld; advance = 1;
      look(vq[i].name, vq[i].e_ren, vq[i].e_wen, vq[i].e_stall, vq[i].e_out);
      chk32({vq[i].name, ".daddr"}, daddr, vq[i].e_daddr);
      chk32({vq[i].name, ".dstore"}, dstore, vq[i].wdata);
      tick();
    end

    // LW with three miss cycles then a hit and advance.
    do_reset();
    set_req(1, 0, 0, 0, 32'h100, 32'h0); advance = 0;
    for (int i = 0; i < 3; i++) begin
      look("lw3_wait", 1, 0, 1, 32'h0);
      tick();
    end
    dhit = 1; dload = 32'hDEADBEEF; advance = 1;
    look("lw3_hit", 1, 0, 0, 32'hDEADBEEF);
    tick();
    idle_in();
    look("lw3_after", 0, 0, 0, 32'h0);
    tick();
    set_req(1, 0, 0, 0, 32'h104, 32'h0); advance = 0;
    look("lw3_idle_again", 1, 0, 1, 32'h0);
    tick();

    // LW hit without advance: result replayed while held, no new request.
    do_reset();
    set_req(1, 0, 0, 0, 32'h100, 32'h0);
    dhit = 1; dload = 32'hDEADBEEF; advance = 0;
    look("held_hit", 1, 0, 0, 32'hDEADBEEF);
    tick();
    dhit = 0; dload = 32'h0;
    for (int i = 0; i < 2; i++) begin
      look("held_wait", 0, 0, 0, 32'hDEADBEEF);
      tick();
    end
    advance = 1;
    look("held_adv", 0, 0, 0, 32'hDEADBEEF);
    tick();
    idle_in();
    look("held_release", 0, 0, 0, 32'h0);
    tick();

    // LL then SC to the same word succeeds and consumes the reservation.
    do_reset();
    set_req(1, 0, 1, 0, 32'h200, 32'h0); dhit = 1; dload = 32'h55;
    look("llsc_ll", 1, 0, 0, 32'h55);
    tick();
    idle_in();
    look("llsc_gap", 0, 0, 0, 32'h0);
    look_link("llsc_gap", 1, 32'h200);
    tick();
    set_req(0, 1, 0, 1, 32'h200, 32'h7); dhit = 1;
    look("llsc_sc", 0, 1, 0, 32'h1);
    tick();
    idle_in();
    look_link("llsc_after", 0, 32'h200);

    // Snoop between LL and SC makes the SC fail quietly.
    do_reset();
    set_req(1, 0, 1, 0, 32'h200, 32'h0); dhit = 1; dload = 32'h66;
    tick();
    idle_in(); snoop_inv = 1; snoop_addr = 32'h202;
    look("snp_gap", 0, 0, 0, 32'h0);
    tick();
    snoop_inv = 0;
    set_req(0, 1, 0, 1, 32'h200, 32'h7); dhit = 0;
    look("snp_sc", 0, 0, 0, 32'h0);
    look_link("snp_sc", 0, 32'h200);
    tick();

    // Reset in the middle of an outstanding load.
    do_reset();
    set_req(1, 0, 1, 0, 32'h100, 32'h0); dhit = 1;
    tick();
    set_req(1, 0, 0, 0, 32'h104, 32'h0); dhit = 0; advance = 0;
    look("rstb_busy", 1, 0, 1, 32'h0);
    tick();
    RST = 1; dhit = 1; dload = 32'h99;
    look("rstb_rst", 0, 0, 0, 32'h0);
    tick();
    RST = 0; idle_in();
    look("rstb_after", 0, 0, 0, 32'h0);
    look_link("rstb_after", 0, 32'h0);
    tick();
    set_req(1, 0, 0, 0, 32'h104, 32'h0); dhit = 0; advance = 0;
    look("rstb_idle", 1, 0, 1, 32'h0);
    tick();

    // LL completing alongside a matching snoop keeps the reservation.
    do_reset();
    set_req(1, 0, 1, 0, 32'h300, 32'h0); dhit = 1; dload = 32'h77;
    snoop_inv = 1; snoop_addr = 32'h300;
    look("ll_vs_snp", 1, 0, 0, 32'h77);
    tick();
    idle_in();
    look_link("ll_vs_snp", 1, 32'h300);

    // Own plain store to the linked word drops the reservation.
    do_reset();
    set_req(1, 0, 1, 0, 32'h104, 32'h0); dhit = 1;
    tick();
    set_req(0, 1, 0, 0, 32'h105, 32'h3); dhit = 1;
    look("sw_clr", 0, 1, 0, 32'h0);
    tick();
    idle_in();
    look_link("sw_clr", 0, 32'h104);

    // Randomized run against the reference model.
    do_reset();
    m_held = 0; m_hv = '0; m_lv = 0; m_la = '0; m_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      RST = ($urandom_range(0, 63) == 0);
      if (!m_pend) begin
        kind = $urandom_range(0, 5);
        case (kind)
          0:       set_req(0, 0, 0, 0, pick_addr(), $urandom);
          1:       set_req(1, 0, 0, 0, pick_addr(), $urandom);
          2:       set_req(1, 0, 1, 0, pick_addr(), $urandom);
          3:       set_req(0, 1, 0, 0, pick_addr(), $urandom);
          4:       set_req(0, 1, 0, 1, pick_addr(), $urandom);
          default: set_req(1, 1, 0, 0, pick_addr(), $urandom);
        endcase
      end
      dhit = ($urandom_range(0, 2) != 0);
      dload = $urandom;
      advance = 1'($urandom_range(0, 1));
      snoop_inv = ($urandom_range(0, 3) == 0);
      snoop_addr = pick_addr();
      #2;

      e_daddr = addr_in & 32'hFFFF_FFFC;
      wr = memwrite_in;
      rd = memread_in && !memwrite_in;
      scf = sc_in && memwrite_in && !(m_lv && (m_la == e_daddr));
      e_ren = 0; e_wen = 0; e_stall = 0; e_out = '0;
      if (!RST) begin
        if (m_held) begin
          e_out = m_hv;
        end else begin
          e_ren = rd;
          e_wen = wr && !scf;
          e_stall = (e_ren || e_wen) && !dhit;
          if (e_ren && dhit)             e_out = dload;
          else if (e_wen && dhit && sc_in) e_out = 32'd1;
        end
      end
      chk1("rnd.dREN", dREN, e_ren);
      chk1("rnd.dWEN", dWEN, e_wen);
      chk1("rnd.mem_stall", mem_stall, e_stall);
      chk32("rnd.dmemload_out", dmemload_out, e_out);
      chk32("rnd.daddr", daddr, e_daddr);
      chk32("rnd.dstore", dstore, wdata_in);
      chk1("rnd.link_valid", link_valid, m_lv);
      chk32("rnd.link_addr", link_addr, m_la);

      if (RST) begin
        m_held = 0; m_hv = '0; m_lv = 0; m_la = '0; m_pend = 0;
      end else begin
        done = (e_ren || e_wen) && dhit;
        if (done && e_ren && ll_in) begin
          m_lv = 1; m_la = e_daddr;
        end else if ((snoop_inv && ((snoop_addr & 32'hFFFF_FFFC) == m_la)) ||
                     (done && e_wen && (e_daddr == m_la))) begin
          m_lv = 0;
        end
        if (m_held) begin
          if (advance) m_held = 0;
        end else if (done) begin
          m_hv = e_out;
          if (!advance) m_held = 1;
        end
        m_pend = e_stall;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
